// File: rtl/tile_fetch.sv
// tile_fetch: text-mode tile map feeding the VGA glyph path.
//   Holds a TILE_COLS x TILE_ROWS map of VAL_W-bit tile values. Each clock the
//   tile under the beam (hcount/vcount) is read and appears on value one clock
//   later. hcount/vcount/bright are delayed two clocks so bitgen stays aligned
//   with the glyph stage that follows this one. Game logic writes tiles through
//   a valid/ready port, and a clear engine blanks the whole map after reset or
//   on clr_start.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   hcount, vcount, bright   raster position / active-video flag (in)
//   value                    tile value under the beam, 1 clk latency (out)
//   hcount_d, vcount_d,
//   bright_d                 raster inputs delayed 2 clk (out)
//   wr_valid/wr_ready        tile write handshake; wr_col, wr_row, wr_data
//   wr_err                   1-clk pulse after an accepted out-of-range write
//   clr_start, busy          clear request / clear engine running
// Optional feature macro TILE_CURSOR_EN: adds cur_col, cur_row inputs and a
//   blinking cursor_d output aligned with the *_d outputs.
module tile_fetch #(
  parameter int TILE_COLS = 80,
  parameter int TILE_ROWS = 60,
  parameter int VAL_W     = 4,
  parameter int CLR_VAL   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       hcount,
  input  logic [9:0]       vcount,
  input  logic             bright,
  output logic [VAL_W-1:0] value,
  output logic [9:0]       hcount_d,
  output logic [9:0]       vcount_d,
  output logic             bright_d,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [6:0]       wr_col,
  input  logic [5:0]       wr_row,
  input  logic [VAL_W-1:0] wr_data,
  output logic             wr_err,
  input  logic             clr_start,
  output logic             busy
`ifdef TILE_CURSOR_EN
  ,
  input  logic [6:0]       cur_col,
  input  logic [5:0]       cur_row,
  output logic             cursor_d
`endif
);

  localparam int DEPTH = TILE_COLS * TILE_ROWS;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_IDLE  = 1'b1;

  logic [0:0]       state;
  logic [AW-1:0]    clr_cnt;
  logic [VAL_W-1:0] mem [DEPTH];

  // ---------------- read path ----------------
  logic [6:0]    rd_col;
  logic [5:0]    rd_row;
  logic          rd_in;
  logic [AW-1:0] rd_addr;

  assign rd_col  = hcount[9:3];
  assign rd_row  = vcount[8:3];
  assign rd_in   = (hcount < 10'(TILE_COLS * 8)) && (vcount < 10'(TILE_ROWS * 8));
  // Off-screen samples are steered to address 0 so the map never wraps;
  // the result is discarded anyway.
  assign rd_addr = rd_in ? (AW'(rd_row) * AW'(TILE_COLS) + AW'(rd_col)) : '0;

  // Registered read: same-address write in this clock returns the old data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) value <= '0;
    else     value <= rd_in ? mem[rd_addr] : '0;
  end

  logic [1:0][9:0] h_pipe, v_pipe;
  logic [1:0]      b_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_pipe <= '0;
      v_pipe <= '0;
      b_pipe <= '0;
    end else begin
      h_pipe <= {h_pipe[0], hcount};
      v_pipe <= {v_pipe[0], vcount};
      b_pipe <= {b_pipe[0], bright};
    end
  end

  assign hcount_d = h_pipe[1];
  assign vcount_d = v_pipe[1];
  assign bright_d = b_pipe[1];

  // ---------------- write path / clear engine ----------------
  logic          accept, wr_in, we;
  logic [AW-1:0] wr_addr, waddr;
  logic [VAL_W-1:0] wdata;

  assign busy     = (state == S_CLEAR);
  assign wr_ready = (state == S_IDLE);
  assign accept   = wr_ready && wr_valid;
  assign wr_in    = (wr_col < 7'(TILE_COLS)) && (wr_row < 6'(TILE_ROWS));
  assign wr_addr  = AW'(wr_row) * AW'(TILE_COLS) + AW'(wr_col);

  // The clear engine owns the write port while busy; user writes only in IDLE.
  assign we    = busy || (accept && wr_in);
  assign waddr = busy ? clr_cnt : wr_addr;
  assign wdata = busy ? VAL_W'(CLR_VAL) : wr_data;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_CLEAR;
      clr_cnt <= '0;
      wr_err  <= 1'b0;
    end else begin
      wr_err <= accept && !wr_in;
      case (state)
        S_CLEAR: begin
          if (clr_cnt == LAST) state <= S_IDLE;
          else                 clr_cnt <= clr_cnt + 1'b1;
        end
        default: begin
          // A write presented with clr_start is still stored this edge;
          // the clear then overwrites it.
          if (clr_start) begin
            state   <= S_CLEAR;
            clr_cnt <= '0;
          end
        end
      endcase
    end
  end

`ifdef TILE_CURSOR_EN
  // ---------------- blinking cursor ----------------
  logic [4:0] frame_cnt;
  logic       blink;
  logic [1:0] cur_pipe;
  logic       cur_hit;

  // A frame ends when vcount wraps back to 0; v_pipe[0] is last clock's vcount.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      blink     <= 1'b1;
    end else if (vcount == 10'd0 && v_pipe[0] != 10'd0) begin
      frame_cnt <= frame_cnt + 1'b1;
      if (frame_cnt == 5'd31) blink <= ~blink;
    end
  end

  assign cur_hit = rd_in && blink && (rd_col == cur_col) && (rd_row == cur_row);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur_pipe <= '0;
    else     cur_pipe <= {cur_pipe[0], cur_hit};
  end

  assign cursor_d = cur_pipe[1];
`endif

endmodule

// File: tb/tb_tile_fetch.sv
// Bench for tile_fetch: table-driven write/read vectors, hand sequences for
// clear/reset corner cases, and randomized traffic against a reference model.
module tb_tile_fetch;
  localparam int COLS  = 80;
  localparam int ROWS  = 60;
  localparam int DEPTH = COLS * ROWS;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] hcount, vcount;
  logic       bright;
  logic [3:0] value;
  logic [9:0] hcount_d, vcount_d;
  logic       bright_d;
  logic       wr_valid, wr_ready;
  logic [6:0] wr_col;
  logic [5:0] wr_row;
  logic [3:0] wr_data;
  logic       wr_err, clr_start, busy;

  always #5 clk = ~clk;

  tile_fetch dut (
    .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount), .bright(bright),
    .value(value), .hcount_d(hcount_d), .vcount_d(vcount_d), .bright_d(bright_d),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_col(wr_col), .wr_row(wr_row),
    .wr_data(wr_data), .wr_err(wr_err), .clr_start(clr_start), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: tile map as a flat array, clear modelled as instant with
  // a remaining-busy cycle count; value is only predicted when no clear ran.
  logic [3:0] mem_m [DEPTH];
  int         busy_left;
  logic [9:0] h1_m, v1_m, exp_hd, exp_vd;
  logic       b1_m, exp_bd, exp_err, val_known;
  logic [3:0] exp_val;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 30) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    logic [3:0] nv;
    logic       ne;
    nv = (hcount < 640 && vcount < 480) ? mem_m[int'(vcount >> 3) * COLS + int'(hcount >> 3)] : 4'h0;
    val_known = (busy_left == 0);
    ne = 1'b0;
    if (busy_left > 0) busy_left--;
    else begin
      if (wr_valid) begin
        if (wr_col < COLS && wr_row < ROWS) mem_m[int'(wr_row) * COLS + int'(wr_col)] = wr_data;
        else ne = 1'b1;
      end
      if (clr_start) begin
        foreach (mem_m[i]) mem_m[i] = 4'h0;
        busy_left = DEPTH;
      end
    end
    exp_hd = h1_m; exp_vd = v1_m; exp_bd = b1_m;
    h1_m = hcount; v1_m = vcount; b1_m = bright;
    exp_val = nv; exp_err = ne;
    @(posedge clk);
    @(negedge clk);
    chk("busy", busy, busy_left != 0);
    chk("wr_ready", wr_ready, busy_left == 0);
    chk("wr_err", wr_err, exp_err);
    chk("hcount_d", hcount_d, exp_hd);
    chk("vcount_d", vcount_d, exp_vd);
    chk("bright_d", bright_d, exp_bd);
    if (val_known) chk("value", value, exp_val);
  endtask

  task automatic idle_inputs();
    wr_valid = 0; clr_start = 0; wr_col = 0; wr_row = 0; wr_data = 0;
  endtask

  // Called at a negedge; asserts reset, checks reset outputs, releases.
  task automatic do_reset(input int hold);
    rst = 1'b1;
    #1;
    chk("rst_value", value, 0);
    chk("rst_hcount_d", hcount_d, 0);
    chk("rst_vcount_d", vcount_d, 0);
    chk("rst_bright_d", bright_d, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_wr_err", wr_err, 0);
    chk("rst_busy", busy, 1);
    repeat (hold) @(negedge clk);
    rst = 1'b0;
    busy_left = DEPTH;
    h1_m = 0; v1_m = 0; b1_m = 0;
    foreach (mem_m[i]) mem_m[i] = 4'h0;
  endtask

  task automatic wait_clear();
    int n = 0;
    while (busy && n < 6000) begin
      tick();
      n++;
    end
    chk("busy_len", n, DEPTH);
  endtask

  task automatic rand_reads(input int n, input bit do_writes);
    for (int i = 0; i < n; i++) begin
      hcount = 10'($urandom_range(0, 799));
      vcount = 10'($urandom_range(0, 524));
      bright = (hcount < 640 && vcount < 480);
      wr_valid = do_writes ? 1'($urandom_range(0, 1)) : 1'b0;
      wr_col  = 7'($urandom_range(0, 85));
      wr_row  = 6'($urandom_range(0, 63));
      wr_data = 4'($urandom);
      tick();
    end
    idle_inputs();
  endtask

  typedef struct packed {
    logic [6:0] col; logic [5:0] row; logic [3:0] data; logic err;
  } wvec_t;
  typedef struct packed {
    logic [9:0] h; logic [9:0] v; logic b; logic [3:0] exp;
  } rvec_t;

  wvec_t wv[6];
  rvec_t rv[15];

  initial begin
    wv[0] = '{7'd5,   6'd2,  4'hA, 1'b0};
    wv[1] = '{7'd80,  6'd0,  4'hF, 1'b1};
    wv[2] = '{7'd0,   6'd60, 4'h3, 1'b1};
    wv[3] = '{7'd79,  6'd59, 4'h7, 1'b0};
    wv[4] = '{7'd0,   6'd0,  4'h1, 1'b0};
    wv[5] = '{7'd127, 6'd63, 4'h5, 1'b1};

    rv[0]  = '{10'd40,  10'd16,  1'b1, 4'hA};
    rv[1]  = '{10'd47,  10'd23,  1'b1, 4'hA};
    rv[2]  = '{10'd39,  10'd16,  1'b1, 4'h0};
    rv[3]  = '{10'd48,  10'd16,  1'b1, 4'h0};
    rv[4]  = '{10'd40,  10'd15,  1'b1, 4'h0};
    rv[5]  = '{10'd40,  10'd24,  1'b1, 4'h0};
    rv[6]  = '{10'd632, 10'd472, 1'b1, 4'h7};
    rv[7]  = '{10'd639, 10'd479, 1'b1, 4'h7};
    rv[8]  = '{10'd0,   10'd0,   1'b1, 4'h1};
    rv[9]  = '{10'd7,   10'd7,   1'b1, 4'h1};
    rv[10] = '{10'd8,   10'd0,   1'b1, 4'h0};
    rv[11] = '{10'd0,   10'd8,   1'b1, 4'h0};
    rv[12] = '{10'd700, 10'd100, 1'b0, 4'h0};
    rv[13] = '{10'd640, 10'd472, 1'b0, 4'h0};
    rv[14] = '{10'd632, 10'd480, 1'b0, 4'h0};

    rst = 1'b1; hcount = 0; vcount = 0; bright = 0;
    idle_inputs();
    busy_left = DEPTH;

    // Power-up clear, then the whole map reads zero.
    @(negedge clk);
    do_reset(3);
    wait_clear();
    rand_reads(200, 1'b0);

    // Table writes, including out-of-range coordinates.
    foreach (wv[i]) begin
      wr_valid = 1; wr_col = wv[i].col; wr_row = wv[i].row; wr_data = wv[i].data;
      tick();
      chk("tbl_wr_err", wr_err, wv[i].err);
      idle_inputs();
      tick();
    end

    // Table reads: the written tile, its neighbours, edges and off-screen.
    foreach (rv[i]) begin
      hcount = rv[i].h; vcount = rv[i].v; bright = rv[i].b;
      tick();
      chk("tbl_value", value, rv[i].exp);
    end
    hcount = 0; vcount = 0; bright = 0;
    tick(); tick();
    chk("tbl_bright_d_offscreen", bright_d, 1'b0);

    // Random writes and reads.
    rand_reads(800, 1'b1);
    rand_reads(300, 1'b0);

    // Clear with a write held: first write stored, clear, then held write retried.
    wr_valid = 1; wr_col = 7'd10; wr_row = 6'd10; wr_data = 4'h9; clr_start = 1;
    tick();
    clr_start = 0;
    wait_clear();
    tick();
    wr_valid = 0;
    hcount = 10'd83; vcount = 10'd85; bright = 1;
    tick();
    chk("held_wr_value", value, 4'h9);
    hcount = 10'd88;
    tick();
    chk("held_wr_neighbour", value, 4'h0);
    rand_reads(300, 1'b0);

    // Reset in the middle of a clear restarts it from address 0.
    clr_start = 1;
    tick();
    clr_start = 0;
    repeat (2000) tick();
    do_reset(2);
    wait_clear();
    rand_reads(200, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
